rr_grant_scheduler: RTL and testbench



---
 rtl/rr_grant_scheduler_if.sv | 27 ++
 rtl/rr_grant_scheduler.sv | 143 ++++++++++++++
 tb/tb_rr_grant_scheduler.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rr_grant_scheduler_if.sv
// Request/grant bundle between the agents and the round-robin scheduler.
// Latency: none, wires only.
// Backpressure: none; an agent holds req high until it is granted and done.
interface rr_grant_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 5
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic               gnt_valid;
  logic [ID_W-1:0]    gnt_id;
  logic               expired;
  logic [CNT_W-1:0]   hold_cnt;

  // Agents drive requests and observe grants.
  modport master (
    output req,
    input  gnt, gnt_valid, gnt_id, expired, hold_cnt
  );

  // The scheduler observes requests and drives grants.
  modport slave (
    input  req,
    output gnt, gnt_valid, gnt_id, expired, hold_cnt
  );
endinterface

// File: rtl/rr_grant_scheduler.sv
// Round-robin owner selection for one shared resource, with a max-hold timer.
// Latency: grant registered 1 cycle after req is sampled; one dead cycle between grants.
// Backpressure: owner keeps the grant while requesting; revoked after MAX_HOLD if others wait.
module rr_grant_scheduler #(
  parameter int NUM_REQ  = 4,
  parameter int ID_W     = 2,
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic               clock,
  input  logic               reset,
  rr_grant_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic               vld_q, vld_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               exp_q, exp_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;

  logic [ID_W-1:0]    win_id;
  logic               win_hit;
  logic [NUM_REQ-1:0] win_oh;
  logic               owner_req;
  logic               others_wait;
  logic               timer_hit;
  logic [CNT_W-1:0]   cnt_sat;

  // Rotating search starting just after the last released owner.
  always_comb begin
    int              idx;
    logic [ID_W-1:0] cand;
    win_hit = 1'b0;
    win_id  = '0;
    idx     = 0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx  = (int'(ptr_q) + k) % NUM_REQ;
      cand = ID_W'(idx);
      if (!win_hit && bus.req[cand]) begin
        win_hit = 1'b1;
        win_id  = cand;
      end
    end
  end

  assign win_oh      = NUM_REQ'(1) << win_id;
  assign owner_req   = |(bus.req & gnt_q);
  assign others_wait = |(bus.req & ~gnt_q);
  assign timer_hit   = (MAX_HOLD != 0) && (cnt_q == CNT_W'(MAX_HOLD));

  // Hold counter increment, saturating at MAX_HOLD (or all-ones when unlimited).
  always_comb begin
    cnt_sat = cnt_q + CNT_W'(1);
    if (MAX_HOLD != 0) begin
      if (cnt_q >= CNT_W'(MAX_HOLD)) cnt_sat = cnt_q;
    end else begin
      if (&cnt_q) cnt_sat = cnt_q;
    end
  end

  // Next-state and next-output decode.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    vld_d   = vld_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    exp_d   = 1'b0;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE, RELEASE: begin
        if (|bus.req) begin
          state_d = GRANT;
          gnt_d   = win_oh;
          vld_d   = 1'b1;
          id_d    = win_id;
          cnt_d   = CNT_W'(1);
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
          vld_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        // A voluntary drop takes precedence, so a coincident timer hit is not an expiry.
        if (!owner_req || (timer_hit && others_wait)) begin
          state_d = RELEASE;
          gnt_d   = '0;
          vld_d   = 1'b0;
          cnt_d   = '0;
          ptr_d   = id_q;
          exp_d   = owner_req;
        end else begin
          cnt_d = cnt_sat;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        vld_d   = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // State and output registers; synchronous reset makes agent 0 the first winner.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      vld_q   <= 1'b0;
      id_q    <= '0;
      cnt_q   <= '0;
      exp_q   <= 1'b0;
      ptr_q   <= ID_W'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      vld_q   <= vld_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = vld_q;
  assign bus.gnt_id    = id_q;
  assign bus.expired   = exp_q;
  assign bus.hold_cnt  = cnt_q;

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Scenario bench for rr_grant_scheduler: stimulus and expected outputs queued per cycle.
// Latency: each queued expectation is compared #1 after the edge that produces it.
// Backpressure: not applicable; the bench drives req directly.
module tb_rr_grant_scheduler;

  typedef struct packed {
    logic       rst;
    logic [3:0] req;
  } stim_t;

  typedef struct packed {
    logic [3:0] gnt;
    logic       vld;
    logic [1:0] id;
    logic       id_chk;
    logic       expired;
    logic [4:0] cnt;
  } exp_t;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  stim_t stim_q[$];
  exp_t  sb[$];

  rr_grant_scheduler_if #(.NUM_REQ(4), .ID_W(2), .CNT_W(5)) bus ();

  rr_grant_scheduler #(
    .NUM_REQ (4),
    .ID_W    (2),
    .MAX_HOLD(16),
    .CNT_W   (5)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic exp_t grant_e(int a, int k);
    exp_t e;
    logic [3:0] one;
    one       = 4'b0001;
    e.gnt     = one << a;
    e.vld     = 1'b1;
    e.id      = 2'(a);
    e.id_chk  = 1'b1;
    e.expired = 1'b0;
    e.cnt     = 5'(k);
    return e;
  endfunction

  function automatic exp_t dead_e(logic expd);
    exp_t e;
    e         = '0;
    e.expired = expd;
    return e;
  endfunction

  function automatic exp_t reset_e();
    exp_t e;
    e        = '0;
    e.id_chk = 1'b1;
    return e;
  endfunction

  function automatic stim_t st(logic r, logic [3:0] q);
    stim_t s;
    s.rst = r;
    s.req = q;
    return s;
  endfunction

  task automatic test_reset();
    stim_t s;
    exp_t  e;
    for (int i = 0; i < 3; i++) begin
      stim_q.push_back(st(1'b1, 4'b1111)); sb.push_back(reset_e());
    end
    stim_q.push_back(st(1'b0, 4'b1111)); sb.push_back(grant_e(0, 1));
    stim_q.push_back(st(1'b0, 4'b0000)); sb.push_back(dead_e(1'b0));
    stim_q.push_back(st(1'b0, 4'b0000)); sb.push_back(dead_e(1'b0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      reset = s.rst; bus.req = s.req;
      @(posedge clock); #1;
      e = sb.pop_front();
      checks++;
      if (bus.gnt !== e.gnt || bus.gnt_valid !== e.vld || bus.expired !== e.expired ||
          bus.hold_cnt !== e.cnt || (e.id_chk && bus.gnt_id !== e.id)) begin
        failures++;
        $display("FAIL reset t=%0t got gnt=%b vld=%b id=%0d exp=%b cnt=%0d want gnt=%b vld=%b id=%0d exp=%b cnt=%0d",
                 $time, bus.gnt, bus.gnt_valid, bus.gnt_id, bus.expired, bus.hold_cnt,
                 e.gnt, e.vld, e.id, e.expired, e.cnt);
      end
    end
  endtask

  task automatic test_short_burst();
    stim_t s;
    exp_t  e;
    // last owner was 0, so agent 2 is found on the scan 1,2
    for (int k = 1; k <= 5; k++) begin
      stim_q.push_back(st(1'b0, 4'b0100)); sb.push_back(grant_e(2, k));
    end
    stim_q.push_back(st(1'b0, 4'b0000)); sb.push_back(dead_e(1'b0));
    stim_q.push_back(st(1'b0, 4'b0000)); sb.push_back(dead_e(1'b0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      reset = s.rst; bus.req = s.req;
      @(posedge clock); #1;
      e = sb.pop_front();
      checks++;
      if (bus.gnt !== e.gnt || bus.gnt_valid !== e.vld || bus.expired !== e.expired ||
          bus.hold_cnt !== e.cnt || (e.id_chk && bus.gnt_id !== e.id)) begin
        failures++;
        $display("FAIL short_burst t=%0t got gnt=%b vld=%b id=%0d exp=%b cnt=%0d want gnt=%b vld=%b id=%0d exp=%b cnt=%0d",
                 $time, bus.gnt, bus.gnt_valid, bus.gnt_id, bus.expired, bus.hold_cnt,
                 e.gnt, e.vld, e.id, e.expired, e.cnt);
      end
    end
  endtask

  task automatic test_rotate();
    stim_t s;
    exp_t  e;
    stim_q.push_back(st(1'b1, 4'b0000)); sb.push_back(reset_e());
    for (int g = 0; g < 5; g++) begin
      for (int k = 1; k <= 16; k++) begin
        stim_q.push_back(st(1'b0, 4'b1111)); sb.push_back(grant_e(g % 4, k));
      end
      stim_q.push_back(st(1'b0, 4'b1111)); sb.push_back(dead_e(1'b1));
    end
    stim_q.push_back(st(1'b0, 4'b0000)); sb.push_back(dead_e(1'b0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      reset = s.rst; bus.req = s.req;
      @(posedge clock); #1;
      e = sb.pop_front();
      checks++;
      if (bus.gnt !== e.gnt || bus.gnt_valid !== e.vld || bus.expired !== e.expired ||
          bus.hold_cnt !== e.cnt || (e.id_chk && bus.gnt_id !== e.id)) begin
        failures++;
        $display("FAIL rotate t=%0t got gnt=%b vld=%b id=%0d exp=%b cnt=%0d want gnt=%b vld=%b id=%0d exp=%b cnt=%0d",
                 $time, bus.gnt, bus.gnt_valid, bus.gnt_id, bus.expired, bus.hold_cnt,
                 e.gnt, e.vld, e.id, e.expired, e.cnt);
      end
    end
  endtask

  task automatic test_single_owner();
    stim_t s;
    exp_t  e;
    for (int k = 1; k <= 40; k++) begin
      stim_q.push_back(st(1'b0, 4'b0010)); sb.push_back(grant_e(1, (k > 16) ? 16 : k));
    end
    stim_q.push_back(st(1'b0, 4'b0000)); sb.push_back(dead_e(1'b0));
    stim_q.push_back(st(1'b0, 4'b0000)); sb.push_back(dead_e(1'b0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      reset = s.rst; bus.req = s.req;
      @(posedge clock); #1;
      e = sb.pop_front();
      checks++;
      if (bus.gnt !== e.gnt || bus.gnt_valid !== e.vld || bus.expired !== e.expired ||
          bus.hold_cnt !== e.cnt || (e.id_chk && bus.gnt_id !== e.id)) begin
        failures++;
        $display("FAIL single_owner t=%0t got gnt=%b vld=%b id=%0d exp=%b cnt=%0d want gnt=%b vld=%b id=%0d exp=%b cnt=%0d",
                 $time, bus.gnt, bus.gnt_valid, bus.gnt_id, bus.expired, bus.hold_cnt,
                 e.gnt, e.vld, e.id, e.expired, e.cnt);
      end
    end
  endtask

  task automatic test_drop_at_expiry();
    stim_t s;
    exp_t  e;
    // last owner was 1: scan 2,3,0 picks 2 although 0 is also requesting
    for (int k = 1; k <= 16; k++) begin
      stim_q.push_back(st(1'b0, 4'b0101)); sb.push_back(grant_e(2, k));
    end
    stim_q.push_back(st(1'b0, 4'b0001)); sb.push_back(dead_e(1'b0));
    stim_q.push_back(st(1'b0, 4'b0001)); sb.push_back(grant_e(0, 1));
    stim_q.push_back(st(1'b0, 4'b0000)); sb.push_back(dead_e(1'b0));
    stim_q.push_back(st(1'b0, 4'b0000)); sb.push_back(dead_e(1'b0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      reset = s.rst; bus.req = s.req;
      @(posedge clock); #1;
      e = sb.pop_front();
      checks++;
      if (bus.gnt !== e.gnt || bus.gnt_valid !== e.vld || bus.expired !== e.expired ||
          bus.hold_cnt !== e.cnt || (e.id_chk && bus.gnt_id !== e.id)) begin
        failures++;
        $display("FAIL drop_at_expiry t=%0t got gnt=%b vld=%b id=%0d exp=%b cnt=%0d want gnt=%b vld=%b id=%0d exp=%b cnt=%0d",
                 $time, bus.gnt, bus.gnt_valid, bus.gnt_id, bus.expired, bus.hold_cnt,
                 e.gnt, e.vld, e.id, e.expired, e.cnt);
      end
    end
  endtask

  task automatic test_reset_mid_grant();
    stim_t s;
    exp_t  e;
    for (int k = 1; k <= 7; k++) begin
      stim_q.push_back(st(1'b0, 4'b1000)); sb.push_back(grant_e(3, k));
    end
    stim_q.push_back(st(1'b1, 4'b1001)); sb.push_back(reset_e());
    stim_q.push_back(st(1'b0, 4'b1001)); sb.push_back(grant_e(0, 1));
    stim_q.push_back(st(1'b0, 4'b0000)); sb.push_back(dead_e(1'b0));
    stim_q.push_back(st(1'b0, 4'b0000)); sb.push_back(dead_e(1'b0));
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      reset = s.rst; bus.req = s.req;
      @(posedge clock); #1;
      e = sb.pop_front();
      checks++;
      if (bus.gnt !== e.gnt || bus.gnt_valid !== e.vld || bus.expired !== e.expired ||
          bus.hold_cnt !== e.cnt || (e.id_chk && bus.gnt_id !== e.id)) begin
        failures++;
        $display("FAIL reset_mid_grant t=%0t got gnt=%b vld=%b id=%0d exp=%b cnt=%0d want gnt=%b vld=%b id=%0d exp=%b cnt=%0d",
                 $time, bus.gnt, bus.gnt_valid, bus.gnt_id, bus.expired, bus.hold_cnt,
                 e.gnt, e.vld, e.id, e.expired, e.cnt);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus.req  = 4'b0000;
    test_reset();
    test_short_burst();
    test_rotate();
    test_single_owner();
    test_drop_at_expiry();
    test_reset_mid_grant();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
